// File: rtl/id_stage_hazard.sv
// Decode stage: register file, immediate generation and the ID/EX pipeline register,
// with valid/ready handshake, flush, WB->ID bypass and load-use bubble insertion.
module id_stage_hazard #(
  parameter int XLEN      = 32,
  parameter int NUM_REGS  = 32,
  parameter int BYPASS_WB = 1,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [XLEN-1:0]             pc_in,
  input  logic [31:0]                 instr_in,
  input  logic                        if_valid,
  output logic                        id_ready,
  input  logic                        ex_ready,
  input  logic                        flush,
  input  logic [XLEN-1:0]             rd_in,
  input  logic [$clog2(NUM_REGS)-1:0] rd,
  input  logic                        load_regfile,
  output logic                        ex_valid,
  output logic [XLEN-1:0]             pc_out,
  output logic [31:0]                 instruction_out,
  output logic [XLEN-1:0]             rs1_out,
  output logic [XLEN-1:0]             rs2_out,
  output logic [XLEN-1:0]             imm_out,
  output logic                        uses_rs1_out,
  output logic                        uses_rs2_out,
  output logic [CNT_W-1:0]            bubble_cnt
);

  localparam int RW = $clog2(NUM_REGS);
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [4:0]      rs1_f, rs2_f, ld_rd;
  logic [RW-1:0]   rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm;
  logic [31:0]     imm32;
  logic [6:0]      opcode;
  logic            uses_rs1, uses_rs2, hazard;

  assign rs1_f   = instr_in[19:15];
  assign rs2_f   = instr_in[24:20];
  assign rs1_idx = rs1_f[RW-1:0];
  assign rs2_idx = rs2_f[RW-1:0];
  assign opcode  = instr_in[6:0];

  // A WB write to the register being read wins over the stored value only with BYPASS_WB.
  assign rs1_val = (rs1_idx == '0) ? '0 :
                   (BYPASS_WB != 0 && load_regfile && rd == rs1_idx) ? rd_in : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0) ? '0 :
                   (BYPASS_WB != 0 && load_regfile && rd == rs2_idx) ? rd_in : regs[rs2_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (load_regfile && rd != '0) begin
      regs[rd] <= rd_in;
    end
  end

  always_comb begin
    imm32    = '0;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr_in[31]}}, instr_in[31:20]};
      OP_STORE: begin
        imm32    = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        imm32    = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25],
                    instr_in[11:8], 1'b0};
        uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        imm32    = {instr_in[31:12], 12'b0};
        uses_rs1 = 1'b0;
      end
      OP_JAL: begin
        imm32    = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20],
                    instr_in[30:21], 1'b0};
        uses_rs1 = 1'b0;
      end
      OP_REG:  uses_rs2 = 1'b1;
      default: ;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

  // The loaded value is not available until after EX, so a dependent reader must wait a cycle.
  assign ld_rd  = instruction_out[11:7];
  assign hazard = ex_valid && (instruction_out[6:0] == OP_LOAD) && (ld_rd != 5'd0) &&
                  if_valid && ((uses_rs1 && rs1_f == ld_rd) || (uses_rs2 && rs2_f == ld_rd));

  // Handshake: IF offers instr_in with if_valid and it is consumed on an edge where
  // if_valid && id_ready; ID offers the ID/EX register with ex_valid and it is consumed
  // on an edge where ex_valid && ex_ready. Flush always accepts (and drops) the input.
  assign id_ready = flush | (ex_ready & ~hazard);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid        <= 1'b0;
      pc_out          <= '0;
      instruction_out <= NOP;
      rs1_out         <= '0;
      rs2_out         <= '0;
      imm_out         <= '0;
      uses_rs1_out    <= 1'b0;
      uses_rs2_out    <= 1'b0;
      bubble_cnt      <= '0;
    end else if (flush) begin
      ex_valid        <= 1'b0;
      instruction_out <= NOP;
    end else if (!ex_ready) begin
      ex_valid        <= ex_valid;
    end else if (hazard) begin
      ex_valid        <= 1'b0;
      instruction_out <= NOP;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else begin
      ex_valid        <= if_valid;
      pc_out          <= pc_in;
      instruction_out <= instr_in;
      rs1_out         <= rs1_val;
      rs2_out         <= rs2_val;
      imm_out         <= imm;
      uses_rs1_out    <= uses_rs1;
      uses_rs2_out    <= uses_rs2;
    end
  end

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: default instance plus a BYPASS_WB=0 instance and a
// CNT_W=2 instance, all driven by the same stimulus.
module tb_id_stage_hazard;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, instr_in, rd_in;
  logic [4:0]  rd;
  logic        if_valid, ex_ready, flush, load_regfile;

  logic        id_ready, ex_valid, uses_rs1_out, uses_rs2_out;
  logic [31:0] pc_out, instruction_out, rs1_out, rs2_out, imm_out;
  logic [15:0] bubble_cnt;

  logic        nb_id_ready, nb_ex_valid, nb_u1, nb_u2;
  logic [31:0] nb_pc, nb_instr, nb_rs1_out, nb_rs2, nb_imm;
  logic [15:0] nb_cnt;

  logic        sat_id_ready, sat_ex_valid, sat_u1, sat_u2;
  logic [31:0] sat_pc, sat_instr, sat_rs1, sat_rs2, sat_imm;
  logic [1:0]  sat_bubble_cnt;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  id_stage_hazard dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .if_valid(if_valid),
    .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush), .rd_in(rd_in), .rd(rd),
    .load_regfile(load_regfile), .ex_valid(ex_valid), .pc_out(pc_out),
    .instruction_out(instruction_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .imm_out(imm_out), .uses_rs1_out(uses_rs1_out), .uses_rs2_out(uses_rs2_out),
    .bubble_cnt(bubble_cnt));

  id_stage_hazard #(.BYPASS_WB(0)) dut_nb (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .if_valid(if_valid),
    .id_ready(nb_id_ready), .ex_ready(ex_ready), .flush(flush), .rd_in(rd_in), .rd(rd),
    .load_regfile(load_regfile), .ex_valid(nb_ex_valid), .pc_out(nb_pc),
    .instruction_out(nb_instr), .rs1_out(nb_rs1_out), .rs2_out(nb_rs2),
    .imm_out(nb_imm), .uses_rs1_out(nb_u1), .uses_rs2_out(nb_u2), .bubble_cnt(nb_cnt));

  id_stage_hazard #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_in(pc_in), .instr_in(instr_in), .if_valid(if_valid),
    .id_ready(sat_id_ready), .ex_ready(ex_ready), .flush(flush), .rd_in(rd_in), .rd(rd),
    .load_regfile(load_regfile), .ex_valid(sat_ex_valid), .pc_out(sat_pc),
    .instruction_out(sat_instr), .rs1_out(sat_rs1), .rs2_out(sat_rs2),
    .imm_out(sat_imm), .uses_rs1_out(sat_u1), .uses_rs2_out(sat_u2),
    .bubble_cnt(sat_bubble_cnt));

  // driver helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_add(input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] d, input logic [4:0] s1,
                                         input logic [11:0] im);
    return {im, s1, 3'b010, d, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] d, input logic [19:0] im);
    return {im, d, 7'b0110111};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %0h exp 0", ex_valid); end
    checks++; if (instruction_out !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", instruction_out, NOP); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble_cnt got %0d exp 0", bubble_cnt); end
    checks++; if (pc_out !== 32'd0 || rs1_out !== 32'd0 || imm_out !== 32'd0) begin errors++; $display("FAIL reset_regs got pc %h rs1 %h imm %h exp 0", pc_out, rs1_out, imm_out); end
    rst = 1'b1;
    // traffic: write x7, issue LW x3, then a dependent ADD stalls
    load_regfile = 1'b1; rd = 5'd7; rd_in = 32'h0000_1234;
    if_valid = 1'b1; instr_in = enc_lw(5'd3, 5'd0, 12'd0); pc_in = 32'h100;
    tick();
    load_regfile = 1'b0;
    instr_in = enc_add(5'd4, 5'd3, 5'd1); pc_in = 32'h104;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL reset_pre_stall_id_ready got %0h exp 0", id_ready); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_ex_valid got %0h exp 0", ex_valid); end
    checks++; if (instruction_out !== NOP) begin errors++; $display("FAIL reset_mid_instr got %h exp %h", instruction_out, NOP); end
    checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid_bubble got %0d exp 0", bubble_cnt); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_release_id_ready got %0h exp 1", id_ready); end
    for (int i = 1; i < 32; i++) begin
      instr_in = enc_add(5'd0, 5'(i), 5'(i)); pc_in = 32'(i * 4);
      tick();
      checks++; if (rs1_out !== 32'd0 || rs2_out !== 32'd0) begin errors++; $display("FAIL reset_reg_x%0d got %h/%h exp 0", i, rs1_out, rs2_out); end
    end
    checks++; if (ex_valid !== 1'b1 || pc_out !== 32'd124) begin errors++; $display("FAIL reset_after_sweep got v %0h pc %h exp 1 7c", ex_valid, pc_out); end
  endtask

  task automatic test_bypass();
    load_regfile = 1'b1; rd = 5'd5; rd_in = 32'hDEAD_BEEF;
    instr_in = enc_add(5'd6, 5'd5, 5'd0); pc_in = 32'h200;
    tick();
    checks++; if (rs1_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_same_cycle got %h exp deadbeef", rs1_out); end
    checks++; if (nb_rs1_out !== 32'd0) begin errors++; $display("FAIL nobypass_same_cycle got %h exp 0", nb_rs1_out); end
    checks++; if (ex_valid !== 1'b1 || pc_out !== 32'h200) begin errors++; $display("FAIL bypass_issue got v %0h pc %h exp 1 200", ex_valid, pc_out); end
    load_regfile = 1'b0; pc_in = 32'h204;
    tick();
    checks++; if (nb_rs1_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nobypass_next_cycle got %h exp deadbeef", nb_rs1_out); end
    load_regfile = 1'b1; rd = 5'd0; rd_in = 32'hFFFF_FFFF;
    instr_in = enc_add(5'd6, 5'd0, 5'd0); pc_in = 32'h208;
    tick();
    checks++; if (rs1_out !== 32'd0) begin errors++; $display("FAIL bypass_x0 got %h exp 0", rs1_out); end
    load_regfile = 1'b0;
  endtask

  task automatic test_load_use();
    instr_in = enc_lw(5'd3, 5'd2, 12'd8); pc_in = 32'h300;
    tick();
    checks++; if (ex_valid !== 1'b1 || imm_out !== 32'd8 || uses_rs1_out !== 1'b1 || uses_rs2_out !== 1'b0) begin errors++; $display("FAIL lw_issue got v %0h imm %h u %0h%0h exp 1 8 10", ex_valid, imm_out, uses_rs1_out, uses_rs2_out); end
    instr_in = enc_add(5'd4, 5'd3, 5'd1); pc_in = 32'h304;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL load_use_id_ready got %0h exp 0", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0 || instruction_out !== NOP) begin errors++; $display("FAIL load_use_bubble got v %0h instr %h exp 0 %h", ex_valid, instruction_out, NOP); end
    checks++; if (bubble_cnt !== 16'd1) begin errors++; $display("FAIL load_use_count got %0d exp 1", bubble_cnt); end
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL load_use_release got %0h exp 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || instruction_out !== enc_add(5'd4, 5'd3, 5'd1) || pc_out !== 32'h304) begin errors++; $display("FAIL load_use_issue got v %0h instr %h pc %h", ex_valid, instruction_out, pc_out); end
    // LUI reads no register, so no bubble
    instr_in = enc_lw(5'd3, 5'd0, 12'd0); pc_in = 32'h308;
    tick();
    instr_in = enc_lui(5'd3, 20'h12345); pc_in = 32'h30C;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL lui_no_hazard got %0h exp 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b1 || imm_out !== 32'h1234_5000 || uses_rs1_out !== 1'b0 || bubble_cnt !== 16'd1) begin errors++; $display("FAIL lui_issue got v %0h imm %h u1 %0h cnt %0d", ex_valid, imm_out, uses_rs1_out, bubble_cnt); end
    // dependency through rs2
    instr_in = enc_lw(5'd3, 5'd0, 12'd0); pc_in = 32'h310;
    tick();
    instr_in = enc_add(5'd4, 5'd1, 5'd3); pc_in = 32'h314;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL load_use_rs2 got %0h exp 0", id_ready); end
    tick();
    checks++; if (bubble_cnt !== 16'd2 || ex_valid !== 1'b0) begin errors++; $display("FAIL load_use_rs2_bubble got cnt %0d v %0h exp 2 0", bubble_cnt, ex_valid); end
    tick();
    checks++; if (ex_valid !== 1'b1 || pc_out !== 32'h314) begin errors++; $display("FAIL load_use_rs2_issue got v %0h pc %h", ex_valid, pc_out); end
  endtask

  task automatic test_backpressure();
    instr_in = enc_add(5'd6, 5'd5, 5'd0); pc_in = 32'h400;
    tick();
    ex_ready = 1'b0;
    instr_in = enc_add(5'd7, 5'd1, 5'd2); pc_in = 32'h404;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL hold_id_ready_%0d got %0h exp 0", i, id_ready); end
      tick();
      checks++; if (ex_valid !== 1'b1 || pc_out !== 32'h400 || rs1_out !== 32'hDEAD_BEEF || instruction_out !== enc_add(5'd6, 5'd5, 5'd0)) begin errors++; $display("FAIL hold_stable_%0d got v %0h pc %h rs1 %h", i, ex_valid, pc_out, rs1_out); end
    end
    flush = 1'b1;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_id_ready got %0h exp 1", id_ready); end
    tick();
    checks++; if (ex_valid !== 1'b0 || instruction_out !== NOP || pc_out !== 32'h400) begin errors++; $display("FAIL flush_hold got v %0h instr %h pc %h", ex_valid, instruction_out, pc_out); end
    flush = 1'b0; ex_ready = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b1 || pc_out !== 32'h404) begin errors++; $display("FAIL after_flush_issue got v %0h pc %h", ex_valid, pc_out); end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic        u1;
    logic        u2;
  } imm_vec_t;

  task automatic test_immediates();
    imm_vec_t v [8];
    v[0] = '{32'hFFF0_0093, 32'hFFFF_FFFF, 1'b1, 1'b0}; // addi x1,x0,-1
    v[1] = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 1'b1, 1'b1}; // beq x0,x0,-4
    v[2] = '{32'h0040_006F, 32'h0000_0004, 1'b0, 1'b0}; // jal x0,4
    v[3] = '{32'hFE51_2C23, 32'hFFFF_FFF8, 1'b1, 1'b1}; // sw x5,-8(x2)
    v[4] = '{32'h8000_0017, 32'h8000_0000, 1'b0, 1'b0}; // auipc x0,0x80000
    v[5] = '{32'h0000_0033, 32'h0000_0000, 1'b1, 1'b1}; // add x0,x0,x0
    v[6] = '{32'h7FF0_2083, 32'h0000_07FF, 1'b1, 1'b0}; // lw x1,2047(x0)
    v[7] = '{32'h0000_007F, 32'h0000_0000, 1'b1, 1'b0}; // unknown opcode
    for (int i = 0; i < 8; i++) begin
      instr_in = v[i].instr; pc_in = 32'h500 + 32'(i * 4);
      tick();
      checks++; if (imm_out !== v[i].imm) begin errors++; $display("FAIL imm_%0d got %h exp %h", i, imm_out, v[i].imm); end
      checks++; if (uses_rs1_out !== v[i].u1 || uses_rs2_out !== v[i].u2) begin errors++; $display("FAIL uses_%0d got %0h%0h exp %0h%0h", i, uses_rs1_out, uses_rs2_out, v[i].u1, v[i].u2); end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_main;
    exp_main = 16'd2;
    for (int i = 0; i < 3; i++) begin
      instr_in = enc_lw(5'd3, 5'd0, 12'd0); pc_in = 32'h600;
      tick();
      instr_in = enc_add(5'd4, 5'd3, 5'd3); pc_in = 32'h604;
      tick();
      exp_main = exp_main + 16'd1;
      checks++; if (sat_bubble_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt_%0d got %0d exp 3", i, sat_bubble_cnt); end
      checks++; if (bubble_cnt !== exp_main) begin errors++; $display("FAIL main_cnt_%0d got %0d exp %0d", i, bubble_cnt, exp_main); end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; pc_in = '0; instr_in = NOP; rd_in = '0; rd = '0;
    if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0; load_regfile = 1'b0;
    test_reset();
    test_bypass();
    test_load_use();
    test_backpressure();
    test_immediates();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
